// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and helpers for the edge event arbiter: FSM state encoding,
// default channel count and the round-robin index wrap.
package edge_event_arbiter_pkg;

   localparam int N_CH_DEFAULT = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } arb_state_e;

   // Wraps idx back into 0..n-1; callers never exceed 2n-1.
   function automatic int rr_wrap(input int idx, input int n);
      if (idx >= n) begin
         return idx - n;
      end else begin
         return idx;
      end
   endfunction

endpackage

// File: rtl/edge_event_arbiter_edge_capture.sv
// One channel of the arbiter: rising-edge detect, pending latch and sticky
// overflow flag.
module edge_capture (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   input  logic en,
   input  logic load,
   input  logic ovf_clr,
   output logic pend,
   output logic ovf
);

   logic prev_r;
   logic pend_r;
   logic ovf_r;
   logic edge_s;

   assign edge_s = ~prev_r & in;
   assign pend   = pend_r;
   assign ovf    = ovf_r;

   // Edge history, pending latch (new edge beats a load) and overflow (set beats clear)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_r <= 1'b0;
         pend_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         prev_r <= in;
         if (edge_s && en) begin
            pend_r <= 1'b1;
         end else if (!en || load) begin
            pend_r <= 1'b0;
         end else begin
            pend_r <= pend_r;
         end
         if (edge_s && en && pend_r && !load) begin
            ovf_r <= 1'b1;
         end else if (ovf_clr) begin
            ovf_r <= 1'b0;
         end else begin
            ovf_r <= ovf_r;
         end
      end
   end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel rising-edge event scheduler: per-channel capture feeding one
// valid/ready event port through a round-robin pick.
module edge_event_arbiter
   import edge_event_arbiter_pkg::*;
#(
   parameter int N_CH  = N_CH_DEFAULT,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_CH-1:0]  in,
   input  logic [N_CH-1:0]  en,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [IDX_W-1:0] evt_ch,
   output logic [N_CH-1:0]  ovf,
   input  logic             ovf_clr
);

   arb_state_e       state_r;
   arb_state_e       state_nx_s;
   logic             evt_valid_r;
   logic             valid_nx_s;
   logic [IDX_W-1:0] evt_ch_r;
   logic [IDX_W-1:0] ch_nx_s;
   logic [IDX_W-1:0] ptr_r;
   logic [IDX_W-1:0] ptr_nx_s;
   logic [N_CH-1:0]  load_s;
   logic [N_CH-1:0]  pend_s;
   logic [N_CH-1:0]  ovf_s;
   logic             found_s;
   logic [IDX_W-1:0] pick_s;

   for (genvar g = 0; g < N_CH; g++) begin : g_cap
      edge_capture u_cap (
         .clk     (clk),
         .rst_n   (rst_n),
         .in      (in[g]),
         .en      (en[g]),
         .load    (load_s[g]),
         .ovf_clr (ovf_clr),
         .pend    (pend_s[g]),
         .ovf     (ovf_s[g])
      );
   end

   assign evt_valid = evt_valid_r;
   assign evt_ch    = evt_ch_r;
   assign ovf       = ovf_s;

   // Round-robin search: first pending channel at or above ptr, wrapping
   always_comb begin
      int cand;
      cand    = 0;
      found_s = 1'b0;
      pick_s  = '0;
      for (int off = 0; off < N_CH; off++) begin
         cand = rr_wrap(int'(ptr_r) + off, N_CH);
         if (!found_s && pend_s[cand]) begin
            found_s = 1'b1;
            pick_s  = IDX_W'(cand);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Next-state logic: IDLE loads the picked channel, OFFER waits for the handshake
   always_comb begin
      state_nx_s = state_r;
      valid_nx_s = evt_valid_r;
      ch_nx_s    = evt_ch_r;
      ptr_nx_s   = ptr_r;
      load_s     = '0;
      case (state_r)
         IDLE: begin
            if (found_s) begin
               load_s[pick_s] = 1'b1;
               ch_nx_s        = pick_s;
               valid_nx_s     = 1'b1;
               ptr_nx_s       = IDX_W'(rr_wrap(int'(pick_s) + 1, N_CH));
               state_nx_s     = OFFER;
            end else begin
               valid_nx_s = 1'b0;
            end
         end
         OFFER: begin
            if (evt_ready) begin
               valid_nx_s = 1'b0;
               state_nx_s = IDLE;
            end else begin
               valid_nx_s = 1'b1;
            end
         end
         default: begin
            valid_nx_s = 1'b0;
            state_nx_s = IDLE;
         end
      endcase
   end

   // State and registered output port
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         evt_valid_r <= 1'b0;
         evt_ch_r    <= '0;
         ptr_r       <= '0;
      end else begin
         state_r     <= state_nx_s;
         evt_valid_r <= valid_nx_s;
         evt_ch_r    <= ch_nx_s;
         ptr_r       <= ptr_nx_s;
      end
   end

endmodule
